// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions for the memory responder: opcode
// constants, the responder state type and a beat-count helper.
package tl_pkg;

    // A-channel request opcodes
    localparam logic [2:0] TL_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] TL_GET         = 3'd4;

    // D-channel response opcodes
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WBURST = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } tl_state_e;

    // Index of the last beat of a burst of 2^size bytes on an 8-byte bus.
    // Sizes up to 7 are representable so oversized (denied) bursts can
    // still be drained beat by beat.
    function automatic logic [3:0] last_beat(input logic [2:0] size);
        logic [3:0] r;
        r = 4'd0;
        if (size > 3'd3) begin
            r = 4'((5'd1 << (size - 3'd3)) - 5'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/tl_mem_responder_if.sv
// TileLink-UL A/D channel pair between the L2 memory port (master) and the
// memory responder (slave). Signal names carry the slave's direction.
//
// Handshake rule on both channels: a beat transfers on a rising clock edge
// where valid and ready are both high; once valid is raised the sender
// holds valid and every payload field stable until that edge, and valid
// never depends combinationally on the same channel's ready.
interface tl_mem_responder_if #(
    parameter int DATA_W = 64
);
    logic                a_valid_i;
    logic                a_ready_o;
    logic [2:0]          a_opcode_i;
    logic [2:0]          a_param_i;
    logic [2:0]          a_size_i;
    logic [3:0]          a_source_i;
    logic [63:0]         a_address_i;
    logic [DATA_W/8-1:0] a_mask_i;
    logic [DATA_W-1:0]   a_data_i;

    logic                d_valid_o;
    logic                d_ready_i;
    logic [2:0]          d_opcode_o;
    logic [1:0]          d_param_o;
    logic [2:0]          d_size_o;
    logic [3:0]          d_source_o;
    logic [1:0]          d_sink_o;
    logic                d_denied_o;
    logic [DATA_W-1:0]   d_data_o;
    logic                d_corrupt_o;

    modport slave (
        input  a_valid_i, a_opcode_i, a_param_i, a_size_i, a_source_i,
               a_address_i, a_mask_i, a_data_i, d_ready_i,
        output a_ready_o, d_valid_o, d_opcode_o, d_param_o, d_size_o,
               d_source_o, d_sink_o, d_denied_o, d_data_o, d_corrupt_o
    );

    modport master (
        output a_valid_i, a_opcode_i, a_param_i, a_size_i, a_source_i,
               a_address_i, a_mask_i, a_data_i, d_ready_i,
        input  a_ready_o, d_valid_o, d_opcode_o, d_param_o, d_size_o,
               d_source_o, d_sink_o, d_denied_o, d_data_o, d_corrupt_o
    );
endinterface

// File: rtl/tl_mem_array.sv
// Word-addressed backing store: byte-masked synchronous write, asynchronous
// read. Contents are deliberately not reset.
module tl_mem_array #(
    parameter int DATA_W    = 64,
    parameter int MEM_WORDS = 4096,
    parameter     INIT_FILE = "",
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [DATA_W/8-1:0] wmask_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [AW-1:0]       raddr_i,
    output logic [DATA_W-1:0]   rdata_o
);
    logic [DATA_W-1:0] mem_q [MEM_WORDS];

    // Write only the enabled byte lanes of the addressed word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wmask_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tl_mem_responder.sv
// TileLink-UL memory responder: accepts one Get / PutFullData /
// PutPartialData burst at a time, answers after LATENCY cycles, and flags
// out-of-range, misaligned, oversized or unknown-opcode requests as denied.
module tl_mem_responder
    import tl_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 4,
    parameter int MAX_SIZE  = 6,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    tl_mem_responder_if.slave bus,
    output tl_state_e         dbg_state_o
);
    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [64:0] MEM_BYTES = 65'(MEM_WORDS) * 65'd8;
    localparam logic [7:0]  LAT_INIT  = 8'(LATENCY - 1);

    tl_state_e   state_q;
    logic        a_ready_q;
    logic        d_valid_q;
    logic [2:0]  opcode_q;
    logic [2:0]  size_q;
    logic [3:0]  source_q;
    logic [AW-1:0] widx_q;
    logic        denied_q;
    logic [3:0]  last_q;
    logic [3:0]  beat_q;
    logic [7:0]  lat_q;

    logic          a_fire;
    logic          d_fire;
    logic          a_is_get;
    logic          resp_get;
    logic [3:0]    a_last;
    logic          size_bad;
    logic          misaligned;
    logic          out_of_range;
    logic          opcode_bad;
    logic          req_denied;
    logic [63:0]   align_mask;
    logic [64:0]   end_excl;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [DATA_W-1:0] rd_data;
    logic          unused_param;

    // a_ready and d_valid come straight from flops, so neither channel's
    // ready/valid feeds back into the other direction combinationally.
    assign a_fire   = bus.a_valid_i && a_ready_q;
    assign d_fire   = d_valid_q && bus.d_ready_i;
    assign a_is_get = (bus.a_opcode_i == TL_GET);
    assign resp_get = (opcode_q == TL_GET);
    assign a_last   = last_beat(bus.a_size_i);

    // Denial check on the live A header; only meaningful on the first beat.
    assign align_mask   = (64'd1 << bus.a_size_i) - 64'd1;
    assign end_excl     = {1'b0, bus.a_address_i} + (65'd1 << bus.a_size_i);
    assign size_bad     = (int'(bus.a_size_i) > MAX_SIZE);
    assign misaligned   = ((bus.a_address_i & align_mask) != 64'd0);
    assign out_of_range = (end_excl > MEM_BYTES);
    assign opcode_bad   = !(a_is_get || bus.a_opcode_i == TL_PUT_FULL ||
                            bus.a_opcode_i == TL_PUT_PARTIAL);
    assign req_denied   = size_bad || misaligned || out_of_range || opcode_bad;

    // Any non-Get opcode is drained as a data-carrying burst.
    // Array write port: first beat from the live header, later beats from
    // the latched word index plus the beat counter.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = bus.a_address_i[3 +: AW];
        case (state_q)
            ST_IDLE: begin
                wr_en = a_fire && !a_is_get && !req_denied;
            end
            ST_WBURST: begin
                wr_en  = a_fire && !denied_q;
                wr_idx = widx_q + AW'(beat_q);
            end
            default: begin
            end
        endcase
    end

    assign rd_idx = widx_q + AW'(beat_q);

    tl_mem_array #(
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS),
        .INIT_FILE (INIT_FILE),
        .AW        (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_idx),
        .wmask_i (bus.a_mask_i),
        .wdata_i (bus.a_data_i),
        .raddr_i (rd_idx),
        .rdata_o (rd_data)
    );

    // Transaction FSM with registered a_ready/d_valid, header latches and
    // beat/latency counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_ready_q <= 1'b0;
            d_valid_q <= 1'b0;
            opcode_q  <= 3'd0;
            size_q    <= 3'd0;
            source_q  <= 4'd0;
            widx_q    <= '0;
            denied_q  <= 1'b0;
            last_q    <= 4'd0;
            beat_q    <= 4'd0;
            lat_q     <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    a_ready_q <= 1'b1;
                    if (a_fire) begin
                        opcode_q <= bus.a_opcode_i;
                        size_q   <= bus.a_size_i;
                        source_q <= bus.a_source_i;
                        widx_q   <= bus.a_address_i[3 +: AW];
                        denied_q <= req_denied;
                        last_q   <= a_last;
                        if (a_is_get || a_last == 4'd0) begin
                            state_q   <= ST_WAIT;
                            a_ready_q <= 1'b0;
                            lat_q     <= LAT_INIT;
                            beat_q    <= 4'd0;
                        end else begin
                            state_q <= ST_WBURST;
                            beat_q  <= 4'd1;
                        end
                    end
                end
                ST_WBURST: begin
                    if (a_fire) begin
                        if (beat_q == last_q) begin
                            state_q   <= ST_WAIT;
                            a_ready_q <= 1'b0;
                            lat_q     <= LAT_INIT;
                            beat_q    <= 4'd0;
                        end else begin
                            beat_q <= beat_q + 4'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (lat_q == 8'd0) begin
                        state_q   <= ST_RESP;
                        d_valid_q <= 1'b1;
                    end else begin
                        lat_q <= lat_q - 8'd1;
                    end
                end
                ST_RESP: begin
                    if (d_fire) begin
                        if (resp_get && beat_q != last_q) begin
                            beat_q <= beat_q + 4'd1;
                        end else begin
                            state_q   <= ST_IDLE;
                            d_valid_q <= 1'b0;
                            a_ready_q <= 1'b1;
                            beat_q    <= 4'd0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.a_ready_o   = a_ready_q;
    assign bus.d_valid_o   = d_valid_q;
    assign bus.d_opcode_o  = resp_get ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
    assign bus.d_param_o   = 2'd0;
    assign bus.d_size_o    = size_q;
    assign bus.d_source_o  = source_q;
    assign bus.d_sink_o    = 2'd0;
    assign bus.d_denied_o  = denied_q;
    assign bus.d_corrupt_o = resp_get && denied_q;
    // Denied reads return zero rather than whatever the wrapped index holds.
    assign bus.d_data_o    = (d_valid_q && resp_get && !denied_q) ? rd_data : '0;
    assign dbg_state_o     = state_q;

    assign unused_param = ^bus.a_param_i;

endmodule
